rx_frame_parser: RTL and testbench

Byte-level frame receiver between the UART receiver and the work-loading logic. It delimits incoming frames, streams the length and payload bytes through the CRC-32 byte engine, and buffers the payload. Each frame is then either released downstream over a valid/ready byte stream (CRC good) or discarded with an error pulse. Frame format: SOF (0xAA), LEN, LEN payload bytes, then 4 CRC bytes, MSB first.

---
 rtl/rx_frame_parser_pkg.sv | 28 ++
 rtl/rx_frame_parser_if.sv | 28 ++
 rtl/rx_frame_parser_crc.sv | 42 ++++
 rtl/rx_frame_parser.sv | 177 +++++++++++++++++
 tb/tb_rx_frame_parser.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_frame_parser_pkg.sv
// Shared definitions for the frame receiver and the status/LED logic.
//   SOF_BYTE_DEFAULT : default start-of-frame marker
//   CRC32_POLY       : CRC-32 generator polynomial (MSB-first, init 0, no final xor)
//   state_e          : parser FSM states
//   err_code_e       : error codes reported to the status/LED logic
package rx_frame_parser_pkg;

   localparam logic [7:0]  SOF_BYTE_DEFAULT = 8'hAA;
   localparam logic [31:0] CRC32_POLY       = 32'h04C1_1DB7;

   typedef enum logic [2:0] {
      StIdle,
      StLen,
      StPayload,
      StCrc,
      StCheck,
      StDrain
   } state_e;

   typedef enum logic [2:0] {
      ErrNone    = 3'd0,
      ErrCrc     = 3'd1,
      ErrLen     = 3'd2,
      ErrTimeout = 3'd3,
      ErrDrop    = 3'd4
   } err_code_e;

endpackage

// File: rtl/rx_frame_parser_if.sv
// Byte-in / payload-out bundle of the frame receiver.
//   rx_valid, rx_byte         : strobed bytes from the UART receiver
//   out_valid/out_ready       : payload stream handshake, with out_data and out_last
//   frame_ok, crc_err, len_err, timeout_err, drop : one-cycle status pulses
// The master modport is the UART/downstream side, the slave modport is the parser.
interface rx_frame_parser_if;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       frame_ok;
   logic       crc_err;
   logic       len_err;
   logic       timeout_err;
   logic       drop;

   modport master (
      output rx_valid, rx_byte, out_ready,
      input  out_valid, out_data, out_last, frame_ok, crc_err, len_err, timeout_err, drop
   );

   modport slave (
      input  rx_valid, rx_byte, out_ready,
      output out_valid, out_data, out_last, frame_ok, crc_err, len_err, timeout_err, drop
   );
endinterface

// File: rtl/rx_frame_parser_crc.sv
// CRC-32 byte engine, MSB first, initial value 0, no final xor.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : restart from 0; the byte presented with clr is the first one folded in
//   valid        : fold data into the running CRC this cycle
//   data         : input byte
//   crc          : registered running CRC; zero after a frame followed by its own CRC
module rx_frame_parser_crc
   import rx_frame_parser_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clr,
   input  logic        valid,
   input  logic [7:0]  data,
   output logic [31:0] crc
);

   logic [31:0] crc_q;
   logic [31:0] crc_d;

   always_comb begin
      crc_d = clr ? '0 : crc_q;
      for (int i = 7; i >= 0; i--) begin
         if (crc_d[31] ^ data[i]) begin
            crc_d = {crc_d[30:0], 1'b0} ^ CRC32_POLY;
         end else begin
            crc_d = {crc_d[30:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         crc_q <= '0;
      end else if (valid) begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/rx_frame_parser.sv
// Frame receiver: SOF, LEN, LEN payload bytes, 4 CRC bytes (MSB first).
// Payload is buffered and released over out_valid/out_ready only when the CRC residue is zero.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : rx byte strobe in, payload stream out, status pulses (slave modport)
module rx_frame_parser
   import rx_frame_parser_pkg::*;
#(
   parameter int unsigned MAX_LEN        = 64,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter logic [7:0]  SOF_BYTE       = SOF_BYTE_DEFAULT
) (
   input logic              clk,
   input logic              reset_n,
   rx_frame_parser_if.slave bus
);

   localparam int unsigned AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned GW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

   state_e        state_q;
   logic [7:0]    len_q;
   logic [7:0]    cnt_q;
   logic [7:0]    rd_ptr_q;
   logic [GW-1:0] gap_q;
   logic [7:0]    buf_q [MAX_LEN];

   logic          out_valid_q, out_last_q;
   logic [7:0]    out_data_q;
   logic          frame_ok_q, crc_err_q, len_err_q, timeout_err_q, drop_q;

   logic          timed;
   logic          crc_feed;
   logic          crc_clr;
   logic [31:0]   crc_res;
   logic [7:0]    rd_next;

   assign timed    = (state_q == StLen) || (state_q == StPayload) || (state_q == StCrc);
   assign crc_feed = timed & bus.rx_valid;
   // LEN restarts the engine so each frame's residue starts from 0.
   assign crc_clr  = (state_q == StLen) & bus.rx_valid;
   assign rd_next  = rd_ptr_q + 8'd1;

   rx_frame_parser_crc u_crc (
      .clk    (clk),
      .reset_n(reset_n),
      .clr    (crc_clr),
      .valid  (crc_feed),
      .data   (bus.rx_byte),
      .crc    (crc_res)
   );

   // Payload buffer: one write port (PAYLOAD), one read port (DRAIN); content is not reset.
   always_ff @(posedge clk) begin
      if (state_q == StPayload && bus.rx_valid) begin
         buf_q[cnt_q[AW-1:0]] <= bus.rx_byte;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         len_q         <= '0;
         cnt_q         <= '0;
         rd_ptr_q      <= '0;
         gap_q         <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_last_q    <= 1'b0;
         frame_ok_q    <= 1'b0;
         crc_err_q     <= 1'b0;
         len_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         drop_q        <= 1'b0;
      end else begin
         frame_ok_q    <= 1'b0;
         crc_err_q     <= 1'b0;
         len_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         drop_q        <= 1'b0;

         unique case (state_q)
            StIdle: begin
               if (bus.rx_valid && bus.rx_byte == SOF_BYTE) state_q <= StLen;
            end
            StLen: begin
               if (bus.rx_valid) begin
                  len_q <= bus.rx_byte;
                  cnt_q <= '0;
                  if (bus.rx_byte == 8'd0 || bus.rx_byte > MAX_LEN_B) begin
                     len_err_q <= 1'b1;
                     state_q   <= StIdle;
                  end else begin
                     state_q <= StPayload;
                  end
               end
            end
            StPayload: begin
               if (bus.rx_valid) begin
                  if (cnt_q == len_q - 8'd1) begin
                     cnt_q   <= '0;
                     state_q <= StCrc;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
            end
            StCrc: begin
               if (bus.rx_valid) begin
                  if (cnt_q == 8'd3) begin
                     cnt_q   <= '0;
                     state_q <= StCheck;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
            end
            StCheck: begin
               if (crc_res == 32'd0) begin
                  frame_ok_q  <= 1'b1;
                  out_valid_q <= 1'b1;
                  out_data_q  <= buf_q[0];
                  out_last_q  <= (len_q == 8'd1);
                  rd_ptr_q    <= '0;
                  state_q     <= StDrain;
               end else begin
                  crc_err_q <= 1'b1;
                  state_q   <= StIdle;
               end
            end
            StDrain: begin
               // The UART cannot be stalled: bytes here are lost, a SOF is flagged.
               if (bus.rx_valid && bus.rx_byte == SOF_BYTE) drop_q <= 1'b1;
               if (out_valid_q && bus.out_ready) begin
                  if (out_last_q) begin
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     rd_ptr_q    <= '0;
                     state_q     <= StIdle;
                  end else begin
                     rd_ptr_q   <= rd_next;
                     out_data_q <= buf_q[rd_next[AW-1:0]];
                     out_last_q <= (rd_next == len_q - 8'd1);
                  end
               end
            end
            default: state_q <= StIdle;
         endcase

         // Inter-byte gap watchdog; overrides the case above only on idle cycles.
         if (timed) begin
            if (bus.rx_valid) begin
               gap_q <= '0;
            end else if (gap_q == GAP_LAST) begin
               gap_q         <= '0;
               timeout_err_q <= 1'b1;
               state_q       <= StIdle;
            end else begin
               gap_q <= gap_q + 1'b1;
            end
         end else begin
            gap_q <= '0;
         end
      end
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.out_last    = out_last_q;
   assign bus.frame_ok    = frame_ok_q;
   assign bus.crc_err     = crc_err_q;
   assign bus.len_err     = len_err_q;
   assign bus.timeout_err = timeout_err_q;
   assign bus.drop        = drop_q;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Self-checking bench for rx_frame_parser: directed frames plus randomized frames checked
// against a CRC-by-polynomial-division model and a payload scoreboard.
module tb_rx_frame_parser;

   localparam int unsigned MAX_LEN  = 64;
   localparam int unsigned TIMEOUT  = 200;
   localparam logic [7:0]  SOF      = 8'hAA;
   localparam logic [32:0] GEN_POLY = 33'h1_04C1_1DB7;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   rx_frame_parser_if bus ();

   rx_frame_parser #(
      .MAX_LEN       (MAX_LEN),
      .TIMEOUT_CYCLES(TIMEOUT),
      .SOF_BYTE      (SOF)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   int n_ok = 0, n_crc = 0, n_len = 0, n_to = 0, n_drop = 0, n_rise = 0;
   int unsigned ok_cyc, crc_cyc, len_cyc, to_cyc, drop_cyc, rise_cyc;
   logic        ov_prev = 1'b0;
   logic        stall_prev = 1'b0;
   logic [7:0]  stall_data;
   logic        stall_last;
   logic [7:0]  got_data[$];
   logic        got_last[$];
   int unsigned got_cyc[$];

   always @(negedge clk) begin
      int unsigned npulse;
      npulse = $countones({bus.frame_ok, bus.crc_err, bus.len_err, bus.timeout_err, bus.drop});
      if (npulse > 0) check("pulse_exclusive", npulse, 1);
      if (bus.frame_ok)    begin n_ok++;   ok_cyc   = cyc; end
      if (bus.crc_err)     begin n_crc++;  crc_cyc  = cyc; end
      if (bus.len_err)     begin n_len++;  len_cyc  = cyc; end
      if (bus.timeout_err) begin n_to++;   to_cyc   = cyc; end
      if (bus.drop)        begin n_drop++; drop_cyc = cyc; end
      if (bus.out_valid && !ov_prev) begin n_rise++; rise_cyc = cyc; end
      if (stall_prev && bus.out_valid) begin
         check("stall_hold_data", bus.out_data, stall_data);
         check("stall_hold_last", bus.out_last, stall_last);
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
      stall_last = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
         got_data.push_back(bus.out_data);
         got_last.push_back(bus.out_last);
         got_cyc.push_back(cyc);
      end
      ov_prev = bus.out_valid;
   end

   // ---------------- reference model ----------------
   // CRC as the remainder of (message * x^32) mod G, by long division over the bit stream.
   function automatic logic [31:0] crc_model(input logic [7:0] msg[$]);
      logic [32:0] rem;
      logic [7:0]  cur;
      rem = '0;
      for (int i = 0; i < msg.size() * 8 + 32; i++) begin
         if (i < msg.size() * 8) begin
            cur = msg[i / 8];
            rem = {rem[31:0], cur[7 - (i % 8)]};
         end else begin
            rem = {rem[31:0], 1'b0};
         end
         if (rem[32]) rem = rem ^ GEN_POLY;
      end
      return rem[31:0];
   endfunction

   function automatic void build_frame(input logic [7:0] len, input logic [7:0] pl[$],
                                       output logic [7:0] frm[$]);
      logic [7:0]  msg[$];
      logic [31:0] c;
      msg.push_back(len);
      foreach (pl[i]) msg.push_back(pl[i]);
      c = crc_model(msg);
      frm.delete();
      frm.push_back(SOF);
      foreach (msg[i]) frm.push_back(msg[i]);
      for (int i = 3; i >= 0; i--) frm.push_back(c[8*i +: 8]);
   endfunction

   // A frame is good when its trailer equals the CRC of LEN plus payload.
   function automatic bit model_ok(input logic [7:0] frm[$]);
      logic [7:0]  msg[$];
      logic [31:0] want;
      int          len;
      len = frm[1];
      for (int i = 1; i <= 1 + len; i++) msg.push_back(frm[i]);
      want = {frm[2+len], frm[3+len], frm[4+len], frm[5+len]};
      return crc_model(msg) == want;
   endfunction

   function automatic logic [31:0] outs();
      return {17'd0, bus.out_valid, bus.out_data, bus.out_last, bus.frame_ok, bus.crc_err,
              bus.len_err, bus.timeout_err, bus.drop};
   endfunction

   function automatic int pulses();
      return n_ok + n_crc + n_len + n_to + n_drop;
   endfunction

   // ---------------- stimulus helpers (entered at posedge + 1) ----------------
   int unsigned strobe_cyc;

   task automatic send_byte(input logic [7:0] b, input int idle);
      bus.rx_valid = 1'b1;
      bus.rx_byte  = b;
      strobe_cyc   = cyc;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      bus.rx_byte  = 8'($urandom);
      repeat (idle) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] frm[$]);
      foreach (frm[i]) send_byte(frm[i], $urandom_range(1, 3));
   endtask

   task automatic wait_idle(input bit rnd);
      int k;
      k = 0;
      repeat (3) begin
         if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      while (bus.out_valid && k < 1000) begin
         if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
         k++;
      end
      check("drain_done", (k < 1000), 1);
   endtask

   task automatic clear_got();
      got_data.delete();
      got_last.delete();
      got_cyc.delete();
   endtask

   task automatic check_delivery(input logic [7:0] frm[$], input string tag);
      int len;
      len = frm[1];
      check({tag, "_count"}, got_data.size(), len);
      for (int i = 0; i < len && i < got_data.size(); i++) begin
         check({tag, "_data"}, got_data[i], frm[2+i]);
         check({tag, "_last"}, got_last[i], (i == len - 1));
      end
   endtask

   task automatic good_frame(input string tag);
      logic [7:0] pl[$];
      logic [7:0] frm[$];
      int         b_ok;
      int unsigned s;
      repeat ($urandom_range(1, 8)) pl.push_back(8'($urandom));
      build_frame(8'(pl.size()), pl, frm);
      clear_got();
      b_ok = n_ok;
      bus.out_ready = 1'b1;
      send_frame(frm);
      s = strobe_cyc;
      wait_idle(1'b0);
      check({tag, "_ok"}, n_ok - b_ok, 1);
      check({tag, "_ok_lat"}, ok_cyc - s, 2);
      check_delivery(frm, tag);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0]  pl[$];
      logic [7:0]  frm[$];
      logic [7:0]  frm2[$];
      int          b_ok, b_crc, b_len, b_to, b_drop, b_rise, p0, k;
      int unsigned s;

      bus.rx_valid  = 1'b0;
      bus.rx_byte   = 8'd0;
      bus.out_ready = 1'b0;
      reset_n       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", outs(), 0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("after_reset_outputs", outs(), 0);

      // Directed good frame AA 03 01 02 03 + CRC
      pl = '{8'h01, 8'h02, 8'h03};
      build_frame(8'd3, pl, frm);
      clear_got();
      b_ok = n_ok; b_rise = n_rise;
      bus.out_ready = 1'b1;
      send_frame(frm);
      s = strobe_cyc;
      wait_idle(1'b0);
      check("good_ok", n_ok - b_ok, 1);
      check("good_ok_lat", ok_cyc - s, 2);
      check("good_rise_lat", rise_cyc - s, 2);
      check_delivery(frm, "good");
      if (got_cyc.size() == 3) check("good_burst", got_cyc[2] - got_cyc[0], 2);

      // Same frame with bit 0 of payload byte 02 flipped
      frm2 = frm;
      frm2[3] = frm2[3] ^ 8'h01;
      clear_got();
      b_ok = n_ok; b_crc = n_crc; b_rise = n_rise;
      send_frame(frm2);
      s = strobe_cyc;
      wait_idle(1'b0);
      check("bad_crc_err", n_crc - b_crc, 1);
      check("bad_crc_lat", crc_cyc - s, 2);
      check("bad_no_ok", n_ok - b_ok, 0);
      check("bad_no_valid", n_rise - b_rise, 0);
      check("bad_no_data", got_data.size(), 0);

      // Illegal LEN values, then a good frame proves the parser is back in IDLE
      foreach (pl[i]) pl[i] = 8'd0;
      pl = '{8'h00, 8'h41};
      foreach (pl[i]) begin
         b_len = n_len;
         send_byte(SOF, 1);
         send_byte(pl[i], 1);
         s = strobe_cyc;
         repeat (2) begin @(posedge clk); #1; end
         check("len_err", n_len - b_len, 1);
         check("len_err_lat", len_cyc - s, 1);
      end
      good_frame("after_len");

      // Inter-byte timeout
      b_to = n_to;
      send_byte(SOF, 1);
      send_byte(8'd2, 1);
      send_byte(8'h01, 1);
      s = strobe_cyc;
      k = 0;
      while (n_to == b_to && k < TIMEOUT + 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("timeout_err", n_to - b_to, 1);
      check("timeout_lat_window", (to_cyc - s >= TIMEOUT) && (to_cyc - s <= TIMEOUT + 2), 1);
      good_frame("after_timeout");

      // A long but sub-limit gap inside a frame is tolerated
      pl = '{8'h01, 8'h02};
      build_frame(8'd2, pl, frm);
      clear_got();
      b_to = n_to; b_ok = n_ok;
      send_byte(frm[0], 1);
      send_byte(frm[1], 1);
      send_byte(frm[2], TIMEOUT - 10);
      for (int i = 3; i < frm.size(); i++) send_byte(frm[i], 1);
      wait_idle(1'b0);
      check("near_timeout_none", n_to - b_to, 0);
      check("near_timeout_ok", n_ok - b_ok, 1);
      check_delivery(frm, "near_timeout");

      // SOF during a stalled DRAIN: dropped and flagged, output held
      pl = '{8'h10, 8'h20, 8'h30, 8'h40};
      build_frame(8'd4, pl, frm);
      clear_got();
      bus.out_ready = 1'b0;
      send_frame(frm);
      repeat (3) begin @(posedge clk); #1; end
      check("drain_valid", bus.out_valid, 1);
      check("drain_data0", bus.out_data, 8'h10);
      b_drop = n_drop;
      send_byte(8'h55, 1);
      check("no_drop_non_sof", n_drop - b_drop, 0);
      send_byte(SOF, 2);
      check("drop_pulse", n_drop - b_drop, 1);
      check("drop_lat", drop_cyc - strobe_cyc, 1);
      check("drop_data_held", bus.out_data, 8'h10);
      check("drop_valid_held", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      wait_idle(1'b0);
      check_delivery(frm, "drop");

      // Reset mid-PAYLOAD: immediate, no pulse for the aborted frame afterwards
      p0 = pulses();
      send_byte(SOF, 1);
      send_byte(8'd5, 1);
      send_byte(8'h11, 1);
      send_byte(8'h22, 1);
      reset_n = 1'b0;
      #1;
      check("rst_payload_outputs", outs(), 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (TIMEOUT + 10) begin @(posedge clk); #1; end
      check("rst_payload_no_pulse", pulses() - p0, 0);
      good_frame("after_rst_payload");

      // Reset during a stalled DRAIN drops out_valid without waiting for a clock edge
      pl = '{8'h5A, 8'hC3};
      build_frame(8'd2, pl, frm);
      bus.out_ready = 1'b0;
      send_frame(frm);
      repeat (3) begin @(posedge clk); #1; end
      check("pre_rst_valid", bus.out_valid, 1);
      #2 reset_n = 1'b0;
      #1;
      check("rst_drain_outputs", outs(), 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      good_frame("after_rst_drain");

      // Randomized frames with noise, illegal lengths, corruption and back-pressure
      for (int f = 0; f < 40; f++) begin
         int          kind, len, idx;
         bit          exp_ok;
         logic [7:0]  b;
         kind = $urandom_range(0, 9);
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            if (b == SOF) b = 8'h00;
            send_byte(b, 1);
         end
         clear_got();
         b_ok = n_ok; b_crc = n_crc; b_len = n_len;
         if (kind == 0) begin
            len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
            send_byte(SOF, $urandom_range(1, 3));
            send_byte(8'(len), 1);
            s = strobe_cyc;
            repeat (2) begin @(posedge clk); #1; end
            check("rnd_len_err", n_len - b_len, 1);
            check("rnd_len_lat", len_cyc - s, 1);
         end else begin
            len = $urandom_range(1, MAX_LEN);
            pl.delete();
            repeat (len) pl.push_back(8'($urandom));
            build_frame(8'(len), pl, frm);
            if (kind <= 2) begin
               idx = $urandom_range(2, frm.size() - 1);
               frm[idx] = frm[idx] ^ 8'(1 << $urandom_range(0, 7));
            end
            exp_ok = model_ok(frm);
            send_frame(frm);
            s = strobe_cyc;
            wait_idle(1'b1);
            if (exp_ok) begin
               check("rnd_ok", n_ok - b_ok, 1);
               check("rnd_ok_lat", ok_cyc - s, 2);
               check("rnd_no_crc_err", n_crc - b_crc, 0);
               check_delivery(frm, "rnd");
            end else begin
               check("rnd_crc_err", n_crc - b_crc, 1);
               check("rnd_crc_lat", crc_cyc - s, 2);
               check("rnd_no_ok", n_ok - b_ok, 0);
               check("rnd_no_data", got_data.size(), 0);
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
